vga_pixel_feeder: RTL and testbench

Pixel prefetch stage directly upstream of `vga_control`. It fetches framebuffer pixels from memory in fixed-length read bursts and buffers them in a small FIFO. It pops one pixel per `REQUEST_DATA` pulse and presents it on `VGA_R_IN/VGA_G_IN/VGA_B_IN`. It runs entirely in the `VGA_CLK` domain; the memory side is a simple request/ack plus data-valid read port.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/pixel_fifo.sv | 61 ++++++
 rtl/vga_pixel_feeder.sv | 162 ++++++++++++++++
 tb/tb_vga_pixel_feeder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and frame geometry for the VGA pixel path.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_DISCARD
  } feeder_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with flush; the head entry is always visible on rd_data_o.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  rgb_t                  wr_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output rgb_t                  rd_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  rgb_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  // Flush dominates: a beat arriving in the flush cycle belongs to the old frame.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = count_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/vga_pixel_feeder.sv
// Burst prefetcher feeding vga_control: fills pixel_fifo from memory and pops
// one pixel per REQUEST_DATA into a registered RGB output.
module vga_pixel_feeder
  import vga_pkg::*;
#(
  parameter int          DEPTH        = 32,
  parameter int          BURST        = 8,
  parameter int          FRAME_PIXELS = vga_pkg::FRAME_PIXELS,
  parameter int          ADDR_W       = 19,
  parameter int unsigned BASE_ADDR    = 0,
  parameter logic [23:0] FILL_COLOR   = 24'hFF00FF
) (
  input  logic                      VGA_CLK,
  input  logic                      RESET_N,
  input  logic                      FRAME_START,
  input  logic                      REQUEST_DATA,
  output logic [7:0]                VGA_R_IN,
  output logic [7:0]                VGA_G_IN,
  output logic [7:0]                VGA_B_IN,
  output logic                      MEM_RD_REQ,
  output logic [ADDR_W-1:0]         MEM_RD_ADDR,
  input  logic                      MEM_RD_ACK,
  input  logic                      MEM_RD_VALID,
  input  logic [23:0]               MEM_RD_DATA,
  output logic                      UNDERFLOW,
  output logic [$clog2(DEPTH):0]    LEVEL
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int BW  = $clog2(BURST) + 1;
  localparam int AW1 = ADDR_W + 1;
  // One extra address bit so a frame ending exactly at 2^ADDR_W does not wrap.
  localparam logic [AW1-1:0] BASE_FULL = AW1'(BASE_ADDR);
  localparam logic [AW1-1:0] END_FULL  = AW1'(BASE_ADDR + FRAME_PIXELS);

  feeder_state_t  state_q, state_d;
  logic [AW1-1:0] addr_q, addr_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           pend_q, pend_d;
  rgb_t           rgb_q, rgb_d;
  logic           underflow_q, underflow_d;

  logic           push;
  logic           pop;
  rgb_t           head;
  logic           empty;
  logic [LW-1:0]  level;
  logic           space_ok;
  logic           addr_ok;
  logic           last_beat;

  pixel_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (VGA_CLK),
    .rst_ni    (RESET_N),
    .push_i    (push),
    .wr_data_i (rgb_t'(MEM_RD_DATA)),
    .pop_i     (pop),
    .flush_i   (FRAME_START),
    .rd_data_o (head),
    .level_o   (level),
    .empty_o   (empty)
  );

  assign space_ok  = (level <= LW'(DEPTH - BURST));
  assign addr_ok   = (addr_q < END_FULL);
  assign last_beat = (beat_q == BW'(BURST - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    pend_d  = pend_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (FRAME_START) begin
          addr_d = BASE_FULL;
        end else if (space_ok && addr_ok) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A restart during the handshake is remembered; the burst still has to drain.
        if (FRAME_START) pend_d = 1'b1;
        if (MEM_RD_ACK) begin
          beat_d  = '0;
          pend_d  = 1'b0;
          state_d = (FRAME_START || pend_q) ? ST_DISCARD : ST_RECV;
        end
      end
      ST_RECV: begin
        if (MEM_RD_VALID) begin
          push   = !FRAME_START;
          beat_d = beat_q + BW'(1);
        end
        if (MEM_RD_VALID && last_beat) begin
          state_d = ST_IDLE;
          addr_d  = FRAME_START ? BASE_FULL : addr_q + AW1'(BURST);
        end else if (FRAME_START) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (MEM_RD_VALID) begin
          beat_d = beat_q + BW'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            addr_d  = BASE_FULL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rgb_d       = rgb_q;
    underflow_d = underflow_q;
    pop         = 1'b0;
    if (FRAME_START) begin
      underflow_d = 1'b0;
      if (REQUEST_DATA) rgb_d = rgb_t'(FILL_COLOR);
    end else if (REQUEST_DATA) begin
      if (!empty) begin
        rgb_d = head;
        pop   = 1'b1;
      end else begin
        rgb_d       = rgb_t'(FILL_COLOR);
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      addr_q      <= BASE_FULL;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign VGA_R_IN    = rgb_q.r;
  assign VGA_G_IN    = rgb_q.g;
  assign VGA_B_IN    = rgb_q.b;
  assign MEM_RD_REQ  = (state_q == ST_REQ);
  assign MEM_RD_ADDR = addr_q[ADDR_W-1:0];
  assign UNDERFLOW   = underflow_q;
  assign LEVEL       = level;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Bench for vga_pixel_feeder: queue-based reference model plus a responsive memory model.
module tb_vga_pixel_feeder;

  localparam int          DEPTH  = 32;
  localparam int          BURST  = 8;
  localparam int          FRAME  = 1024;
  localparam int          ADDR_W = 11;
  localparam int          BASE   = 1024;
  localparam logic [23:0] FILL   = 24'hFF00FF;
  localparam int          LW     = $clog2(DEPTH) + 1;

  logic              VGA_CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              FRAME_START = 1'b0;
  logic              REQUEST_DATA = 1'b0;
  logic              MEM_RD_ACK = 1'b0;
  logic              MEM_RD_VALID = 1'b0;
  logic [23:0]       MEM_RD_DATA = '0;
  logic [7:0]        r_o, g_o, b_o;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              uf;
  logic [LW-1:0]     level;

  vga_pixel_feeder #(
    .DEPTH        (DEPTH),
    .BURST        (BURST),
    .FRAME_PIXELS (FRAME),
    .ADDR_W       (ADDR_W),
    .BASE_ADDR    (BASE),
    .FILL_COLOR   (FILL)
  ) dut (
    .VGA_CLK      (VGA_CLK),
    .RESET_N      (RESET_N),
    .FRAME_START  (FRAME_START),
    .REQUEST_DATA (REQUEST_DATA),
    .VGA_R_IN     (r_o),
    .VGA_G_IN     (g_o),
    .VGA_B_IN     (b_o),
    .MEM_RD_REQ   (mem_req),
    .MEM_RD_ADDR  (mem_addr),
    .MEM_RD_ACK   (MEM_RD_ACK),
    .MEM_RD_VALID (MEM_RD_VALID),
    .MEM_RD_DATA  (MEM_RD_DATA),
    .UNDERFLOW    (uf),
    .LEVEL        (level)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pixels the FIFO should hold, expected outputs, next burst address.
  int          q[$];
  logic [23:0] exp_rgb;
  logic        exp_uf;
  int          exp_addr;
  int          lvl_prev;

  // Memory responder state and knobs.
  bit m_out, m_acked, m_discard, new_req;
  int m_cnt, m_gap, m_idx, m_addr, bursts_done, last_req_addr;
  bit stall;
  int lat_min, lat_max, gap_min, gap_max;

  typedef struct {
    logic        req;
    logic        fs;
    logic [23:0] exp_rgb;
    logic        exp_uf;
    int          exp_level;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit req, input bit fs);
    int          start_sz;
    int          tmp;
    bit          v;
    bit          last;
    logic [23:0] d;
    REQUEST_DATA = req;
    FRAME_START  = fs;
    MEM_RD_ACK   = 1'b0;
    MEM_RD_VALID = 1'b0;
    MEM_RD_DATA  = '0;
    v = 0; last = 0; d = '0; new_req = 0;
    start_sz = q.size();
    if (!m_out && mem_req) begin
      new_req       = 1;
      last_req_addr = int'(mem_addr);
      chk("req_addr", 32'(mem_addr), 32'(exp_addr));
      chk("req_in_frame", 32'(exp_addr < BASE + FRAME), 32'd1);
      chk("req_space", 32'(lvl_prev <= DEPTH - BURST), 32'd1);
      m_out = 1; m_acked = 0; m_discard = 0;
      m_addr = int'(mem_addr);
      m_cnt  = $urandom_range(lat_max, lat_min);
    end
    if (m_out && !m_acked) begin
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("req_addr_stable", 32'(mem_addr), 32'(m_addr));
      if (!stall && m_cnt == 0) begin
        MEM_RD_ACK = 1'b1;
        m_acked = 1; m_idx = 0; m_gap = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
    end else if (m_out) begin
      chk("req_drop", 32'(mem_req), 32'd0);
      if (m_gap == 0) begin
        v = 1;
        d = 24'(m_addr - BASE + m_idx);
        MEM_RD_VALID = 1'b1;
        MEM_RD_DATA  = d;
        m_idx++;
        last  = (m_idx == BURST);
        m_gap = $urandom_range(gap_max, gap_min);
      end else begin
        m_gap--;
      end
    end
    lvl_prev = start_sz;
    if (req) begin
      if (fs) exp_rgb = FILL;
      else if (q.size() > 0) begin
        tmp = q.pop_front();
        exp_rgb = 24'(tmp);
      end else begin
        exp_rgb = FILL;
        exp_uf  = 1'b1;
      end
    end
    if (fs) begin
      q.delete();
      exp_uf   = 1'b0;
      exp_addr = BASE;
      if (m_out) m_discard = 1;
    end
    if (v) begin
      if (!m_discard) q.push_back(int'(d));
      if (last) begin
        if (!m_discard) exp_addr += BURST;
        m_out = 0;
        bursts_done++;
      end
    end
    @(posedge VGA_CLK);
    #1;
    chk("level", 32'(level), 32'(q.size()));
    chk("rgb", 32'({r_o, g_o, b_o}), 32'(exp_rgb));
    chk("underflow", 32'(uf), 32'(exp_uf));
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    FRAME_START = 1'b0; REQUEST_DATA = 1'b0;
    MEM_RD_ACK = 1'b0; MEM_RD_VALID = 1'b0; MEM_RD_DATA = '0;
    repeat (2) @(posedge VGA_CLK);
    #1;
    chk("rst_rgb", 32'({r_o, g_o, b_o}), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'(BASE));
    chk("rst_uf", 32'(uf), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    q.delete();
    exp_rgb = '0; exp_uf = 1'b0; exp_addr = BASE; lvl_prev = 0;
    m_out = 0; m_acked = 0; m_discard = 0; bursts_done = 0; new_req = 0;
    @(negedge VGA_CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int popped;
    bit p;
    tbl[0] = '{1'b1, 1'b0, 24'd30, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b0, 24'd31, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b0, 24'd31, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b0, FILL,   1'b1, 0};
    tbl[4] = '{1'b0, 1'b0, FILL,   1'b1, 0};
    tbl[5] = '{1'b0, 1'b1, FILL,   1'b0, 0};
    tbl[6] = '{1'b1, 1'b0, FILL,   1'b1, 0};
    tbl[7] = '{1'b1, 1'b1, FILL,   1'b0, 0};
    tbl[8] = '{1'b0, 1'b0, FILL,   1'b0, 0};

    stall = 0; lat_min = 2; lat_max = 2; gap_min = 1; gap_max = 1;
    do_reset();

    for (int i = 0; i < 300 && bursts_done < 3; i++) step(0, 0);
    chk("fill3_bursts", 32'(bursts_done), 32'd3);
    chk("fill3_level", 32'(level), 32'd24);
    chk("fill3_addr", 32'(mem_addr), 32'(BASE + 24));
    for (int i = 0; i < 300 && bursts_done < 4; i++) step(0, 0);
    chk("fill4_level", 32'(level), 32'd32);
    for (int i = 0; i < 20; i++) begin
      step(0, 0);
      chk("full_no_req", 32'(mem_req), 32'd0);
    end
    $display("seq reset_fill: level=%0d checks=%0d", level, n_checks);

    stall = 1;
    for (int i = 0; i < 30; i++) begin
      step(1, 0);
      chk("uf_pop_data", 32'({r_o, g_o, b_o}), 32'(i));
    end
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].req, tbl[i].fs);
      chk("tbl_rgb", 32'({r_o, g_o, b_o}), 32'(tbl[i].exp_rgb));
      chk("tbl_uf", 32'(uf), 32'(tbl[i].exp_uf));
      chk("tbl_level", 32'(level), 32'(tbl[i].exp_level));
    end
    stall = 0; lat_min = 0; lat_max = 3; gap_min = 0; gap_max = 1;
    b0 = bursts_done;
    for (int i = 0; i < 300 && bursts_done < b0 + 2; i++) step(0, 0);
    chk("uf_realign_bursts", 32'(bursts_done), 32'(b0 + 2));
    chk("uf_realign_addr", 32'(last_req_addr), 32'(BASE));
    chk("uf_realign_level", 32'(level), 32'(BURST));
    $display("seq underflow: checks=%0d", n_checks);

    do_reset();
    lat_min = 0; lat_max = 2; gap_min = 0; gap_max = 1;
    popped = 0;
    for (int cyc = 0; cyc < 6000 && popped < 640; cyc++) begin
      p = (q.size() > 0) && ($urandom_range(3, 0) != 0);
      step(p, 0);
      if (p) begin
        chk("stream_pix", 32'({r_o, g_o, b_o}), 32'(popped));
        popped++;
      end
    end
    chk("stream_count", 32'(popped), 32'd640);
    chk("stream_uf", 32'(uf), 32'd0);
    $display("seq streaming: popped=%0d checks=%0d", popped, n_checks);

    do_reset();
    lat_min = 1; lat_max = 1; gap_min = 0; gap_max = 0;
    for (int i = 0; i < 100 && !(m_out && m_acked && m_idx == 3); i++) step(0, 0);
    chk("flush_at_beat3", 32'(m_idx), 32'd3);
    step(0, 1);
    chk("flush_level", 32'(level), 32'd0);
    for (int i = 0; i < 100 && !new_req; i++) step(0, 0);
    chk("flush_new_req", 32'(new_req), 32'd1);
    chk("flush_realign", 32'(last_req_addr), 32'(BASE));
    $display("seq flush_mid_burst: checks=%0d", n_checks);

    do_reset();
    lat_min = 0; lat_max = 4; gap_min = 0; gap_max = 2;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99, 0) < 45, $urandom_range(499, 0) == 0);
    end
    $display("seq random: bursts=%0d checks=%0d", bursts_done, n_checks);

    do_reset();
    lat_min = 0; lat_max = 1; gap_min = 0; gap_max = 0;
    popped = 0;
    for (int cyc = 0; cyc < 4000 && popped < FRAME; cyc++) begin
      p = (q.size() > 0);
      step(p, 0);
      if (p) begin
        chk("frame_pix", 32'({r_o, g_o, b_o}), 32'(popped));
        popped++;
      end
    end
    chk("frame_count", 32'(popped), 32'(FRAME));
    for (int i = 0; i < 40; i++) begin
      step(1, 0);
      chk("frame_end_no_req", 32'(mem_req), 32'd0);
    end
    chk("frame_end_uf", 32'(uf), 32'd1);
    step(0, 1);
    chk("frame_restart_uf", 32'(uf), 32'd0);
    for (int i = 0; i < 50 && !new_req; i++) step(0, 0);
    chk("frame_restart_req", 32'(new_req), 32'd1);
    chk("frame_restart_addr", 32'(last_req_addr), 32'(BASE));
    $display("seq frame_end: popped=%0d checks=%0d", popped, n_checks);

    do_reset();
    lat_min = 0; lat_max = 0; gap_min = 1; gap_max = 1;
    for (int i = 0; i < 200 && bursts_done < 2; i++) step(i % 2 == 1 && q.size() > 0, 0);
    for (int i = 0; i < 100 && !(m_out && m_acked && m_idx == 2); i++) step(0, 0);
    chk("arst_mid_recv", 32'(m_idx), 32'd2);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_rgb", 32'({r_o, g_o, b_o}), 32'd0);
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'(BASE));
    chk("arst_uf", 32'(uf), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    do_reset();
    $display("seq async_reset: checks=%0d", n_checks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
